// File: rtl/bp_nonsynth_pkg.sv
// ============================================================================
//  Module      : bp_nonsynth_pkg
//  Description : Shared types for the commit/writeback trace replayer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package bp_nonsynth_pkg;

    localparam int bp_nonsynth_data_width_gp = 64;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RUN   = 3'd1,
        GAP   = 3'd2,
        DRAIN = 3'd3,
        DONE  = 3'd4
    } bp_nonsynth_state_e;

    typedef struct packed {
        logic [4:0]                           rd;
        logic [bp_nonsynth_data_width_gp-1:0] data;
        logic [15:0]                          stamp;
    } bp_nonsynth_wb_rec_s;

    // Wrap-safe "now has reached stamp": the signed distance is non-negative.
    function automatic logic bp_nonsynth_due(input logic [15:0] now, input logic [15:0] stamp);
        logic [15:0] diff;
        diff = now - stamp;
        return ~diff[15];
    endfunction

endpackage

`default_nettype wire

// File: rtl/bp_nonsynth_commit_wb_queue.sv
// ============================================================================
//  Module      : bp_nonsynth_commit_wb_queue
//  Description : Strict-FIFO pending-writeback buffer with time-stamped release.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_nonsynth_commit_wb_queue
    import bp_nonsynth_pkg::*;
#(
    parameter int wb_els_p = 8
) (
    input  logic                                 clk_i,
    input  logic                                 reset_i,
    input  logic [15:0]                          cyc_i,
    input  logic                                 push_v_i,
    input  bp_nonsynth_wb_rec_s                  push_rec_i,
    output logic                                 w_v_o,
    output logic [4:0]                           addr_o,
    output logic [bp_nonsynth_data_width_gp-1:0] data_o,
    output logic                                 empty_o,
    output logic                                 full_next_o
);

    localparam int c_ptr_w = $clog2(wb_els_p);
    localparam int c_cnt_w = $clog2(wb_els_p) + 1;

    bp_nonsynth_wb_rec_s r_mem [wb_els_p];
    logic [c_ptr_w-1:0]  r_rd_ptr;
    logic [c_ptr_w-1:0]  r_wr_ptr;
    logic [c_cnt_w-1:0]  r_count;
    logic [c_cnt_w-1:0]  w_count_next;
    bp_nonsynth_wb_rec_s w_head;
    logic                w_empty;
    logic                w_pop;
    logic                w_bypass;
    logic                w_store;
    logic                w_deq;

    assign w_empty = (r_count == '0);
    // An empty queue treats the incoming record as its head, so a zero-delay
    // writeback lands in the same cycle as its commit. The release test uses
    // next cycle's count because the output is registered.
    assign w_head       = w_empty ? push_rec_i : r_mem[r_rd_ptr];
    assign w_pop        = (~w_empty | push_v_i) & bp_nonsynth_due(cyc_i + 16'd1, w_head.stamp);
    assign w_bypass     = w_pop & w_empty;
    assign w_store      = push_v_i & ~w_bypass;
    assign w_deq        = w_pop & ~w_empty;
    assign w_count_next = r_count + c_cnt_w'(w_store) - c_cnt_w'(w_deq);
    assign empty_o      = w_empty;
    assign full_next_o  = (w_count_next == c_cnt_w'(wb_els_p));

    always_ff @(posedge clk_i) begin
        if (w_store) begin
            r_mem[r_wr_ptr] <= push_rec_i;
        end
    end

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_rd_ptr <= '0;
            r_wr_ptr <= '0;
            r_count  <= '0;
            w_v_o    <= 1'b0;
            addr_o   <= '0;
            data_o   <= '0;
        end else begin
            if (w_store) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_w'(1);
            end
            if (w_deq) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_w'(1);
            end
            r_count <= w_count_next;
            w_v_o   <= w_pop;
            if (w_pop) begin
                addr_o <= w_head.rd;
                data_o <= w_head.data;
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/bp_nonsynth_commit_replay.sv
// ============================================================================
//  Module      : bp_nonsynth_commit_replay
//  Description : Replays a recorded trace as commit + lagged writeback streams.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module bp_nonsynth_commit_replay
    import bp_nonsynth_pkg::*;
#(
    parameter int          vaddr_width_p = 39,
    parameter int          instr_width_p = 32,
    parameter int          dword_width_p = 64,
    parameter int          wb_els_p      = 8,
    parameter logic [15:0] cyc_init_p    = 16'h0000
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic                     freeze_i,
    input  logic                     entry_v_i,
    output logic                     entry_ready_o,
    input  logic [vaddr_width_p-1:0] entry_pc_i,
    input  logic [instr_width_p-1:0] entry_instr_i,
    input  logic                     entry_trap_i,
    input  logic [dword_width_p-1:0] entry_cause_i,
    input  logic                     entry_ird_w_v_i,
    input  logic                     entry_frd_w_v_i,
    input  logic [dword_width_p-1:0] entry_data_i,
    input  logic [3:0]               entry_delay_i,
    input  logic                     end_i,
    output logic                     commit_v_o,
    output logic                     commit_exception_o,
    output logic [vaddr_width_p-1:0] commit_pc_o,
    output logic [instr_width_p-1:0] commit_instr_o,
    output logic [dword_width_p-1:0] commit_cause_o,
    output logic                     ird_w_v_o,
    output logic [4:0]               ird_addr_o,
    output logic [dword_width_p-1:0] ird_data_o,
    output logic                     frd_w_v_o,
    output logic [4:0]               frd_addr_o,
    output logic [dword_width_p-1:0] frd_data_o,
    output logic [31:0]              instr_cnt_o,
    output logic                     done_o
);

    bp_nonsynth_state_e  r_state;
    bp_nonsynth_state_e  w_state_next;
    logic [15:0]         r_cyc;
    logic                w_accept;
    logic                w_retire;
    bp_nonsynth_wb_rec_s w_rec;
    logic                w_iq_empty;
    logic                w_fq_empty;
    logic                w_iq_full_next;
    logic                w_fq_full_next;

    assign w_accept    = entry_v_i & entry_ready_o;
    assign w_retire    = w_accept & ~entry_trap_i;
    assign w_rec.rd    = entry_instr_i[11:7];
    assign w_rec.data  = entry_data_i;
    assign w_rec.stamp = r_cyc + 16'd1 + {12'd0, entry_delay_i};

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_cyc <= cyc_init_p;
        end else begin
            r_cyc <= r_cyc + 16'd1;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    w_state_next = RUN;
            RUN: begin
                if (w_accept && entry_trap_i) begin
                    w_state_next = GAP;
                end else if (!w_accept && end_i && !freeze_i) begin
                    w_state_next = DRAIN;
                end
            end
            GAP:     w_state_next = RUN;
            DRAIN:   w_state_next = (w_iq_empty && w_fq_empty) ? DONE : DRAIN;
            DONE:    w_state_next = DONE;
            default: w_state_next = IDLE;
        endcase
    end

    // Ready is registered, so freeze and queue-full act from the following cycle.
    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            r_state            <= IDLE;
            entry_ready_o      <= 1'b0;
            done_o             <= 1'b0;
            commit_v_o         <= 1'b0;
            commit_exception_o <= 1'b0;
            commit_pc_o        <= '0;
            commit_instr_o     <= '0;
            commit_cause_o     <= '0;
            instr_cnt_o        <= '0;
        end else begin
            r_state            <= w_state_next;
            entry_ready_o      <= (w_state_next == RUN) & ~freeze_i & ~w_iq_full_next & ~w_fq_full_next;
            done_o             <= (w_state_next == DONE);
            commit_v_o         <= w_retire;
            commit_exception_o <= w_accept & entry_trap_i;
            if (w_accept) begin
                commit_pc_o    <= entry_pc_i;
                commit_instr_o <= entry_instr_i;
            end
            if (w_accept && entry_trap_i) begin
                commit_cause_o <= entry_cause_i;
            end
            if (w_retire && !(&instr_cnt_o)) begin
                instr_cnt_o <= instr_cnt_o + 32'd1;
            end
        end
    end

    bp_nonsynth_commit_wb_queue #(
        .wb_els_p (wb_els_p)
    ) u_int_queue (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .cyc_i       (r_cyc),
        .push_v_i    (w_retire & entry_ird_w_v_i),
        .push_rec_i  (w_rec),
        .w_v_o       (ird_w_v_o),
        .addr_o      (ird_addr_o),
        .data_o      (ird_data_o),
        .empty_o     (w_iq_empty),
        .full_next_o (w_iq_full_next)
    );

    bp_nonsynth_commit_wb_queue #(
        .wb_els_p (wb_els_p)
    ) u_fp_queue (
        .clk_i       (clk_i),
        .reset_i     (reset_i),
        .cyc_i       (r_cyc),
        .push_v_i    (w_retire & entry_frd_w_v_i),
        .push_rec_i  (w_rec),
        .w_v_o       (frd_w_v_o),
        .addr_o      (frd_addr_o),
        .data_o      (frd_data_o),
        .empty_o     (w_fq_empty),
        .full_next_o (w_fq_full_next)
    );

endmodule

`default_nettype wire

// File: tb/tb_bp_nonsynth_commit_replay.sv
// ============================================================================
//  Module      : tb_bp_nonsynth_commit_replay
//  Description : Self-checking bench against a cycle-indexed trace model.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_bp_nonsynth_commit_replay;

    logic        clk = 1'b0;
    logic        reset_i;
    logic        freeze_i;
    logic        entry_v_i;
    logic        entry_ready_o;
    logic [38:0] entry_pc_i;
    logic [31:0] entry_instr_i;
    logic        entry_trap_i;
    logic [63:0] entry_cause_i;
    logic        entry_ird_w_v_i;
    logic        entry_frd_w_v_i;
    logic [63:0] entry_data_i;
    logic [3:0]  entry_delay_i;
    logic        end_i;
    logic        commit_v_o;
    logic        commit_exception_o;
    logic [38:0] commit_pc_o;
    logic [31:0] commit_instr_o;
    logic [63:0] commit_cause_o;
    logic        ird_w_v_o;
    logic [4:0]  ird_addr_o;
    logic [63:0] ird_data_o;
    logic        frd_w_v_o;
    logic [4:0]  frd_addr_o;
    logic [63:0] frd_data_o;
    logic [31:0] instr_cnt_o;
    logic        done_o;

    always #5 clk = ~clk;

    bp_nonsynth_commit_replay #(
        .vaddr_width_p (39),
        .instr_width_p (32),
        .dword_width_p (64),
        .wb_els_p      (8),
        .cyc_init_p    (16'hFFFE)
    ) dut (
        .clk_i              (clk),
        .reset_i            (reset_i),
        .freeze_i           (freeze_i),
        .entry_v_i          (entry_v_i),
        .entry_ready_o      (entry_ready_o),
        .entry_pc_i         (entry_pc_i),
        .entry_instr_i      (entry_instr_i),
        .entry_trap_i       (entry_trap_i),
        .entry_cause_i      (entry_cause_i),
        .entry_ird_w_v_i    (entry_ird_w_v_i),
        .entry_frd_w_v_i    (entry_frd_w_v_i),
        .entry_data_i       (entry_data_i),
        .entry_delay_i      (entry_delay_i),
        .end_i              (end_i),
        .commit_v_o         (commit_v_o),
        .commit_exception_o (commit_exception_o),
        .commit_pc_o        (commit_pc_o),
        .commit_instr_o     (commit_instr_o),
        .commit_cause_o     (commit_cause_o),
        .ird_w_v_o          (ird_w_v_o),
        .ird_addr_o         (ird_addr_o),
        .ird_data_o         (ird_data_o),
        .frd_w_v_o          (frd_w_v_o),
        .frd_addr_o         (frd_addr_o),
        .frd_data_o         (frd_data_o),
        .instr_cnt_o        (instr_cnt_o),
        .done_o             (done_o)
    );

    // Each pending writeback is known by the absolute cycle it must appear in.
    typedef struct {
        int          rel;
        logic [4:0]  rd;
        logic [63:0] data;
    } wb_t;

    wb_t         iq[$];
    wb_t         fq[$];
    int          last_rel_i;
    int          last_rel_f;
    int          t;
    int          end_cycle;
    int          n_checks;
    int          n_pass;
    int          n_acc;
    bit          freeze_prev;
    bit          trap_prev;
    bit          last_hs;
    bit          exp_cv;
    bit          exp_ce;
    logic [38:0] exp_pc;
    logic [31:0] exp_instr;
    logic [63:0] exp_cause;
    logic [31:0] exp_cnt;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed %h expected %h (t=%0d)", tag, obs, exp, t);
    endtask

    function automatic logic [31:0] addi(input logic [4:0] rd, input logic [11:0] imm);
        return {imm, 5'd0, 3'b000, rd, 7'b0010011};
    endfunction

    task automatic model_reset();
        iq.delete();
        fq.delete();
        last_rel_i  = -100;
        last_rel_f  = -100;
        t           = 0;
        end_cycle   = 1 << 30;
        freeze_prev = 1'b0;
        trap_prev   = 1'b0;
        exp_cv      = 1'b0;
        exp_ce      = 1'b0;
        exp_pc      = '0;
        exp_instr   = '0;
        exp_cause   = '0;
        exp_cnt     = '0;
    endtask

    task automatic check_reset_outputs();
        chk("rst_ready",    64'(entry_ready_o),      64'd0);
        chk("rst_commit_v", 64'(commit_v_o),         64'd0);
        chk("rst_exc",      64'(commit_exception_o), 64'd0);
        chk("rst_pc",       64'(commit_pc_o),        64'd0);
        chk("rst_instr",    64'(commit_instr_o),     64'd0);
        chk("rst_cause",    commit_cause_o,          64'd0);
        chk("rst_ird_v",    64'(ird_w_v_o),          64'd0);
        chk("rst_ird_addr", 64'(ird_addr_o),         64'd0);
        chk("rst_ird_data", ird_data_o,              64'd0);
        chk("rst_frd_v",    64'(frd_w_v_o),          64'd0);
        chk("rst_frd_addr", 64'(frd_addr_o),         64'd0);
        chk("rst_frd_data", frd_data_o,              64'd0);
        chk("rst_cnt",      64'(instr_cnt_o),        64'd0);
        chk("rst_done",     64'(done_o),             64'd0);
    endtask

    // One clock cycle: drive at edge+1, check at negedge, advance the model at the edge.
    task automatic step(input bit v, input bit trap, input bit iw, input bit fw,
                        input logic [3:0] d, input bit e, input bit fz,
                        input logic [38:0] pc, input logic [31:0] instr,
                        input logic [63:0] data, input logic [63:0] cause);
        bit running;
        bit exp_rdy;
        bit hs;
        int ni;
        int nf;
        int r;
        entry_v_i       = v;
        entry_trap_i    = trap;
        entry_ird_w_v_i = iw;
        entry_frd_w_v_i = fw;
        entry_delay_i   = d;
        end_i           = e;
        freeze_i        = fz;
        entry_pc_i      = pc;
        entry_instr_i   = instr;
        entry_data_i    = data;
        entry_cause_i   = cause;
        running = (t >= 1) && (t <= end_cycle) && !trap_prev;
        ni = 0;
        nf = 0;
        foreach (iq[k]) if (iq[k].rel > t) ni++;
        foreach (fq[k]) if (fq[k].rel > t) nf++;
        exp_rdy = running && !freeze_prev && (ni < 8) && (nf < 8);
        @(negedge clk);
        chk("ready",      64'(entry_ready_o),      64'(exp_rdy));
        chk("commit_v",   64'(commit_v_o),         64'(exp_cv));
        chk("commit_exc", 64'(commit_exception_o), 64'(exp_ce));
        if (exp_cv || exp_ce) begin
            chk("commit_pc",    64'(commit_pc_o),    64'(exp_pc));
            chk("commit_instr", 64'(commit_instr_o), 64'(exp_instr));
        end
        if (exp_ce) chk("commit_cause", commit_cause_o, exp_cause);
        chk("instr_cnt", 64'(instr_cnt_o), 64'(exp_cnt));
        chk("done", 64'(done_o), 64'((t >= end_cycle + 2) && (iq.size() == 0) && (fq.size() == 0)));
        if (iq.size() > 0 && iq[0].rel == t) begin
            chk("ird_v",    64'(ird_w_v_o),  64'd1);
            chk("ird_addr", 64'(ird_addr_o), 64'(iq[0].rd));
            chk("ird_data", ird_data_o,      iq[0].data);
            void'(iq.pop_front());
        end else begin
            chk("ird_v", 64'(ird_w_v_o), 64'd0);
        end
        if (fq.size() > 0 && fq[0].rel == t) begin
            chk("frd_v",    64'(frd_w_v_o),  64'd1);
            chk("frd_addr", 64'(frd_addr_o), 64'(fq[0].rd));
            chk("frd_data", frd_data_o,      fq[0].data);
            void'(fq.pop_front());
        end else begin
            chk("frd_v", 64'(frd_w_v_o), 64'd0);
        end
        hs      = v && exp_rdy;
        last_hs = hs;
        exp_cv  = hs && !trap;
        exp_ce  = hs && trap;
        if (hs) begin
            exp_pc    = pc;
            exp_instr = instr;
            if (trap) exp_cause = cause;
        end
        if (hs && !trap) begin
            if (exp_cnt != 32'hFFFF_FFFF) exp_cnt = exp_cnt + 32'd1;
            if (iw) begin
                r = (t + 1 + int'(d) > last_rel_i + 1) ? t + 1 + int'(d) : last_rel_i + 1;
                iq.push_back('{rel: r, rd: instr[11:7], data: data});
                last_rel_i = r;
            end else if (fw) begin
                r = (t + 1 + int'(d) > last_rel_f + 1) ? t + 1 + int'(d) : last_rel_f + 1;
                fq.push_back('{rel: r, rd: instr[11:7], data: data});
                last_rel_f = r;
            end
        end
        if (running && !hs && e && !fz) end_cycle = t;
        freeze_prev = fz;
        trap_prev   = hs && trap;
        @(posedge clk);
        #1;
        t++;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(0, 0, 0, 0, 4'd0, 0, 0, '0, '0, '0, '0);
    endtask

    task automatic rnd_step(input int p_v, input int p_fz, input int p_trap);
        int sel;
        sel = $urandom_range(0, 2);
        step($urandom_range(0, 99) < p_v, $urandom_range(0, 99) < p_trap, sel == 1, sel == 2,
             4'($urandom_range(0, 15)), 0, $urandom_range(0, 99) < p_fz,
             39'({$urandom, $urandom}), $urandom, {$urandom, $urandom}, 64'($urandom_range(0, 15)));
    endtask

    initial begin
        n_checks        = 0;
        n_pass          = 0;
        reset_i         = 1'b0;
        freeze_i        = 1'b0;
        entry_v_i       = 1'b0;
        entry_pc_i      = '0;
        entry_instr_i   = '0;
        entry_trap_i    = 1'b0;
        entry_cause_i   = '0;
        entry_ird_w_v_i = 1'b0;
        entry_frd_w_v_i = 1'b0;
        entry_data_i    = '0;
        entry_delay_i   = '0;
        end_i           = 1'b0;
        model_reset();
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        reset_i = 1'b1;
        idle(1);

        // Four back-to-back ADDIs with zero writeback lag.
        for (int i = 0; i < 4; i++)
            step(1, 0, 1, 0, 4'd0, 0, 0, 39'(64'h1000 + 4 * i), addi(5'(i + 1), 12'(i)),
                 64'(8'h11 * (i + 1)), '0);
        idle(2);
        chk("cnt_after_addi", 64'(instr_cnt_o), 64'd4);

        // Long-delay write ahead of a zero-delay write must release first.
        step(1, 0, 1, 0, 4'd5, 0, 0, 39'h2000, addi(5'd3, 12'd7), 64'hAAAA, '0);
        step(1, 0, 1, 0, 4'd0, 0, 0, 39'h2004, addi(5'd4, 12'd8), 64'hBBBB, '0);
        idle(8);

        // Trap: one exception pulse, one bubble, no writeback.
        step(1, 1, 1, 0, 4'd0, 0, 0, 39'h3000, addi(5'd9, 12'd1), 64'hDEAD, 64'h2);
        for (int i = 0; i < 3; i++) step(1, 0, 0, 0, 4'd0, 0, 0, 39'(64'h3004 + 4 * i), 32'h13, '0, '0);

        // Nine long-delay writes against an eight-deep queue.
        n_acc = 0;
        for (int g = 0; g < 60 && n_acc < 9; g++) begin
            step(1, 0, 1, 0, 4'd15, 0, 0, 39'(64'h4000 + 4 * n_acc), addi(5'(n_acc + 10), 12'd0),
                 64'(n_acc + 64'h100), '0);
            if (last_hs) n_acc++;
        end
        chk("nine_accepted", 64'(n_acc), 64'd9);
        idle(20);

        // Freeze while writebacks are still queued.
        step(1, 0, 0, 1, 4'd6, 0, 0, 39'h5000, addi(5'd2, 12'd0), 64'h5555, '0);
        for (int i = 0; i < 4; i++) step(1, 0, 1, 0, 4'd0, 0, 1, 39'h5004, addi(5'd5, 12'd0), 64'h66, '0);
        idle(10);

        repeat (200) rnd_step(70, 10, 10);

        // Asynchronous reset in the middle of traffic.
        repeat (6) rnd_step(100, 0, 0);
        #2;
        reset_i = 1'b0;
        #1;
        check_reset_outputs();
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_i = 1'b1;
        model_reset();
        idle(1);

        // Stamps straddle the 16-bit counter wrap just after reset.
        step(1, 0, 1, 0, 4'd4, 0, 0, 39'h6000, addi(5'd6, 12'd0), 64'h6666, '0);
        step(1, 0, 0, 1, 4'd4, 0, 0, 39'h6004, addi(5'd7, 12'd0), 64'h7777, '0);
        idle(8);
        repeat (100) rnd_step(60, 10, 10);
        idle(20);

        // End of trace with two writebacks still pending.
        step(1, 0, 1, 0, 4'd10, 0, 0, 39'h7000, addi(5'd8, 12'd0), 64'h8888, '0);
        step(1, 0, 0, 1, 4'd12, 0, 0, 39'h7004, addi(5'd9, 12'd0), 64'h9999, '0);
        for (int i = 0; i < 25; i++) step(0, 0, 0, 0, 4'd0, 1, 0, '0, '0, '0, '0);
        chk("done_final", 64'(done_o), 64'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not reach the summary");
        $fatal(1);
    end

endmodule

`default_nettype wire

// File: doc/bp_nonsynth_commit_replay.md
# bp_nonsynth_commit_replay

Non-synthesizable commit-stream generator that replays a pre-recorded instruction trace, one entry per accepted handshake, and drives commit and register-writeback signals. It is the producer end of the commit/writeback interface that the cosim checker consumes. Each entry's writeback can lag its commit by a programmable number of cycles, so late-writeback ordering is exercised without a full core. It sits in the BE testbench in place of the core's commit stage.

## Interface
- vaddr_width_p, 39, PC width
- instr_width_p, 32, instruction width
- dword_width_p, 64, writeback data width
- wb_els_p, 8, pending-writeback queue depth per register file (power of 2)
- clk_i  in  1  clock
- reset_i  in  1  reset, asynchronous, active-low
- freeze_i  in  1  high: accept no entries, emit no commits; queued writebacks still drain
- entry_v_i  in  1  trace entry valid
- entry_ready_o  out  1  entry accepted when entry_v_i & entry_ready_o
- entry_pc_i  in  vaddr_width_p  committed PC
- entry_instr_i  in  instr_width_p  instruction; rd = instr[11:7]
- entry_trap_i  in  1  entry is a trap, not a retire
- entry_cause_i  in  dword_width_p  trap cause
- entry_ird_w_v_i / entry_frd_w_v_i  in  1 each  int/fp writeback required (mutually exclusive; ignored on trap)
- entry_data_i  in  dword_width_p  writeback data
- entry_delay_i  in  4  writeback lag in cycles after commit
- end_i  in  1  level; trace exhausted
- commit_v_o  out  1  instruction retired
- commit_exception_o  out  1  trap committed
- commit_pc_o / commit_instr_o / commit_cause_o  out  as entry  committed fields
- ird_w_v_o, ird_addr_o[4:0], ird_data_o[dword_width_p-1:0]  out  int writeback
- frd_w_v_o, frd_addr_o[4:0], frd_data_o[dword_width_p-1:0]  out  fp writeback
- instr_cnt_o  out  32  retired-instruction count (traps excluded)
- done_o  out  1  all entries committed, all writebacks emitted

## Operation
- States: IDLE, RUN, GAP, DRAIN, DONE. Reset enters IDLE.
- IDLE -> RUN on the first cycle after reset release.
- RUN: entry_ready_o = ~freeze_i & ~iq_full & ~fq_full.
- In RUN, an accepted non-trap entry produces commit_v_o for one cycle. If it writes a register, a {rd, data, stamp = cyc + 1 + delay} record is pushed to the queue for that file.
- In RUN, an accepted trap entry produces commit_exception_o with commit_cause_o for one cycle, then the FSM moves to GAP.
- GAP: exactly one bubble cycle with entry_ready_o = 0, then back to RUN. A trap inserts no writeback.
- RUN -> DRAIN when end_i and no handshake occur in the same cycle. DRAIN -> DONE once both queues are empty. DONE is absorbing until reset.
- cyc is a free-running 16-bit counter. A queue head is released when $signed(cyc - stamp) >= 0, which is wrap-safe.
- At most one release per file per cycle. Release is strictly FIFO, so a younger short-delay record waits behind an older long-delay one. This preserves the per-register ordering the checker requires.
- instr_cnt_o increments on every commit_v_o pulse and saturates at 2^32-1.

## Timing
- All outputs are registered. Reset values: every *_v_o, commit_exception_o, entry_ready_o and done_o are 0; all data, addr, pc, instr and cause outputs are 0; instr_cnt_o is 0.
- Entry accepted in cycle N -> commit output in cycle N+1.
- Writeback with delay d appears in cycle N+1+d if its queue was empty, otherwise later.
- With d=0, the writeback appears in the same cycle as its commit.
- Back-to-back acceptance at 1 entry per cycle when the queues are not full.
- Queue full: entry_ready_o drops in the same cycle and rises the cycle after a pop.
- Simultaneous push and pop on a full queue is not allowed; a full queue blocks acceptance.
- freeze_i mid-RUN: no acceptance, queues keep releasing, state is held.
- Async reset mid-operation: queues are flushed and all outputs return to their reset values immediately.

## Structure
- bp_nonsynth_pkg holds the state enum (IDLE..DONE) and the bp_nonsynth_wb_rec_s struct {rd[4:0], data, stamp[15:0]}.
- Sub-module bp_nonsynth_commit_wb_queue is instantiated twice (int, fp). It contains a circular buffer of wb_els_p records, the release comparator and full/empty flags.
- The top level holds the FSM, cycle counter, commit output registers and instr counter.

## Test plan
- 4 non-trap ADDIs, rd=1..4, delay 0, data 0x11..0x44 -> commit_v_o on 4 consecutive cycles; ird_w_v_o coincides with each commit; instr_cnt_o=4.
- Entry A (delay 5, rd=3) then entry B (delay 0, rd=4) -> B's writeback is emitted after A's, in cycle N+6 and N+7 respectively.
- Trap with cause 0x2 -> commit_exception_o for 1 cycle, entry_ready_o low for the next cycle, instr_cnt_o unchanged, no writeback.
- 9 entries with delay 15 and wb_els_p=8 -> entry_ready_o drops after the 8th entry and recovers once the first writeback releases.
- cyc preloaded to 0xFFFE, delay 4 -> writeback released correctly across the wrap.
- end_i with 2 writebacks pending -> done_o rises the cycle after the last writeback. Async reset mid-run clears all outputs and the queues.
